// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants, types and helpers for the data memory
package data_memory_pkg;

    localparam int          MMIO_SEL_BIT      = 29;
    localparam logic [1:0]  REG_LED           = 2'd0;
    localparam logic [1:0]  REG_CYCLE         = 2'd1;
    localparam logic [1:0]  REG_TIMER_CMP     = 2'd2;
    localparam logic [1:0]  REG_STATUS        = 2'd3;
    localparam int          STATUS_HIT_BIT    = 0;
    localparam logic [31:0] CMP_RESET_DEFAULT = 32'hFFFF_FFFF;

    // Which register feeds mem_q after the most recent read
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } rd_src_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{lanes[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - one byte lane of synchronous RAM
module data_memory_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  re,
    input  logic [7:0]            d,
    output logic [7:0]            q
);

    logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

    // No reset on array or read register so the tools can map this to block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= d;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - data memory responder: byte-lane RAM plus LED/cycle/timer MMIO
module data_memory
    import data_memory_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] CMP_RESET  = CMP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] mem_addr,
    input  logic [3:0]  mem_ce,
    input  logic [3:0]  mem_we,
    input  logic [31:0] mem_d,
    output logic [31:0] mem_q,
    output logic [7:0]  led,
    output logic        timer_irq
);

    logic                  is_mmio;
    logic [1:0]            reg_sel;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            wr_lanes;
    logic                  is_wr;
    logic                  is_rd;
    logic [3:0]            ram_we;
    logic [3:0]            ram_re;
    logic [31:0]           ram_q;

    logic [31:0]           cycle;
    logic [31:0]           cycle_inc;
    logic [31:0]           cycle_next;
    logic [31:0]           timer_cmp;
    logic [31:0]           cmp_next;
    logic                  status_hit;
    logic                  timer_hit;
    logic                  status_clr;
    logic                  led_wr;
    logic [31:0]           mmio_rdata;

    rd_src_e               rd_src;
    logic [31:0]           rd_mask;
    logic [31:0]           mmio_q;

    assign is_mmio  = mem_addr[MMIO_SEL_BIT];
    assign reg_sel  = mem_addr[1:0];
    assign ram_addr = mem_addr[ADDR_WIDTH-1:0];
    assign wr_lanes = mem_ce & mem_we;
    assign is_wr    = |wr_lanes;
    assign is_rd    = (|mem_ce) && !is_wr;

    // Gating with reset_n keeps the RAM untouched while reset is held
    assign ram_we = wr_lanes & {4{!is_mmio && reset_n}};
    assign ram_re = mem_ce & {4{!is_mmio && is_rd}};

    for (genvar k = 0; k < 4; k++) begin : g_lane
        data_memory_bank #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk  (clk),
            .addr (ram_addr),
            .we   (ram_we[k]),
            .re   (ram_re[k]),
            .d    (mem_d[8*k +: 8]),
            .q    (ram_q[8*k +: 8])
        );
    end

    assign cycle_inc  = cycle + 32'd1;
    assign timer_hit  = (cycle == timer_cmp);
    assign led_wr     = is_mmio && (reg_sel == REG_LED) && wr_lanes[0];
    assign status_clr = is_mmio && (reg_sel == REG_STATUS) && wr_lanes[0]
                        && mem_d[STATUS_HIT_BIT];

    always_comb begin
        cycle_next = cycle_inc;
        cmp_next   = timer_cmp;
        for (int k = 0; k < 4; k++) begin
            if (is_mmio && (reg_sel == REG_CYCLE) && wr_lanes[k]) begin
                cycle_next[8*k +: 8] = mem_d[8*k +: 8];
            end
            if (is_mmio && (reg_sel == REG_TIMER_CMP) && wr_lanes[k]) begin
                cmp_next[8*k +: 8] = mem_d[8*k +: 8];
            end
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (reg_sel)
            REG_LED:       mmio_rdata = {24'd0, led};
            REG_CYCLE:     mmio_rdata = cycle;
            REG_TIMER_CMP: mmio_rdata = timer_cmp;
            default:       mmio_rdata[STATUS_HIT_BIT] = status_hit;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led        <= '0;
            cycle      <= '0;
            timer_cmp  <= CMP_RESET;
            status_hit <= 1'b0;
        end else begin
            if (led_wr) begin
                led <= mem_d[7:0];
            end
            cycle     <= cycle_next;
            timer_cmp <= cmp_next;
            // A compare hit in the same cycle as a W1C clear leaves the flag set
            if (timer_hit) begin
                status_hit <= 1'b1;
            end else if (status_clr) begin
                status_hit <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_src  <= SRC_ZERO;
            rd_mask <= '0;
            mmio_q  <= '0;
        end else if (is_rd) begin
            rd_mask <= lane_mask(mem_ce);
            if (is_mmio) begin
                rd_src <= SRC_MMIO;
                mmio_q <= mmio_rdata & lane_mask(mem_ce);
            end else begin
                rd_src <= SRC_RAM;
            end
        end
    end

    // Bank read registers only load on RAM reads, so mem_q holds across idle/write cycles
    always_comb begin
        mem_q = '0;
        case (rd_src)
            SRC_RAM:  mem_q = ram_q & rd_mask;
            SRC_MMIO: mem_q = mmio_q;
            default:  mem_q = '0;
        endcase
    end

    assign timer_irq = status_hit;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] mem_addr;
    logic [3:0]  mem_ce;
    logic [3:0]  mem_we;
    logic [31:0] mem_d;
    logic [31:0] mem_q;
    logic [7:0]  led;
    logic        timer_irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_q = 32'd0;

    localparam logic [29:0] A_LED    = 30'h2000_0000;
    localparam logic [29:0] A_CYCLE  = 30'h2000_0001;
    localparam logic [29:0] A_CMP    = 30'h2000_0002;
    localparam logic [29:0] A_STATUS = 30'h2000_0003;

    data_memory dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_addr  (mem_addr),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_d     (mem_d),
        .mem_q     (mem_q),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic wr(input logic [29:0] a, input logic [3:0] ce, input logic [3:0] we,
                      input logic [31:0] d);
        mem_addr = a; mem_ce = ce; mem_we = we; mem_d = d;
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [29:0] a, input logic [3:0] ce, input logic [31:0] want);
        exp_q.push_back(want);
        mem_addr = a; mem_ce = ce; mem_we = 4'h0; mem_d = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mem_ce = 4'h0; mem_we = 4'h0;
        @(posedge clk); #1;
    endtask

    // Monitor: classify the request at each edge, compare mem_q mid-cycle
    always begin
        logic was_rd;
        logic was_rst;
        logic [31:0] e;
        @(posedge clk);
        was_rd  = (mem_ce != 4'h0) && ((mem_ce & mem_we) == 4'h0);
        was_rst = reset_n;
        if (!reset_n) last_q = 32'd0;
        @(negedge clk);
        if (was_rst && reset_n) begin
            if (was_rd) begin
                if (exp_q.size() == 0) begin
                    check("read_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", mem_q, e);
                    last_q = e;
                end
            end else begin
                check("hold", mem_q, last_q);
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        mem_addr = '0; mem_ce = '0; mem_we = '0; mem_d = '0;
        @(posedge clk); #1;
        check("rst_mem_q", mem_q, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        reset_n = 1'b1;

        wr(30'h004, 4'hF, 4'hF, 32'hDEAD_BEEF);
        rd(30'h004, 4'hF, 32'hDEAD_BEEF);
        wr(30'h004, 4'h4, 4'h4, 32'h00AA_0000);
        rd(30'h004, 4'hC, 32'hDEAA_0000);
        rd(30'h004, 4'h1, 32'h0000_00EF);
        wr(30'h008, 4'hF, 4'hF, 32'h0000_0000);
        wr(30'h008, 4'h3, 4'hF, 32'h1122_3344);
        rd(30'h008, 4'hF, 32'h0000_3344);
        rd(30'h404, 4'hF, 32'hDEAA_BEEF);
        wr(30'h004, 4'h1, 4'h1, 32'h0000_0011);
        rd(30'h004, 4'hF, 32'hDEAA_BE11);

        wr(A_LED, 4'h1, 4'h1, 32'h0000_005A);
        check("led_write", {24'd0, led}, 32'h5A);
        rd(A_LED, 4'hF, 32'h0000_005A);
        wr(A_LED, 4'h2, 4'h2, 32'h0000_FF00);
        check("led_lane1_ignored", {24'd0, led}, 32'h5A);
        rd(A_LED, 4'hF, 32'h0000_005A);

        wr(A_CYCLE, 4'hF, 4'hF, 32'h0000_0010);
        rd(A_CYCLE, 4'hF, 32'h0000_0010);
        wr(A_CMP, 4'hF, 4'hF, 32'h0000_0015);
        idle(); idle(); idle();
        check("irq_before_hit", {31'd0, timer_irq}, 32'd0);
        idle();
        check("irq_on_hit", {31'd0, timer_irq}, 32'd1);
        wr(A_STATUS, 4'h1, 4'h1, 32'h0000_0000);
        check("irq_w0_no_effect", {31'd0, timer_irq}, 32'd1);
        wr(A_STATUS, 4'h1, 4'h1, 32'h0000_0001);
        check("irq_w1c", {31'd0, timer_irq}, 32'd0);
        rd(A_STATUS, 4'hF, 32'h0000_0000);
        idle();

        mem_addr = 30'h004; mem_ce = 4'hF; mem_we = 4'h0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_mem_q", mem_q, 32'd0);
        check("midrst_led", {24'd0, led}, 32'd0);
        check("midrst_irq", {31'd0, timer_irq}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd(A_CYCLE, 4'hF, 32'h0000_0000);
        rd(A_CMP, 4'hF, 32'hFFFF_FFFF);
        rd(30'h004, 4'hF, 32'hDEAA_BE11);
        rd(30'h008, 4'hF, 32'h0000_3344);
        idle(); idle();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Responder end of the core's data-memory port. It accepts word address, per-lane chip-enable/write-enable and write data from the load/store controller. It returns the addressed word on mem_q with one-cycle registered latency. It contains a byte-lane RAM of 2^ADDR_WIDTH words plus a small MMIO block (LED register, free-running cycle counter, timer compare/status with interrupt), so loads/stores can drive DE10-Nano LEDs and read time.

Parameters:
ADDR_WIDTH, 10, number of word-address bits decoded for RAM (depth = 2^ADDR_WIDTH words, 4 KB default)
CMP_RESET, 32'hFFFF_FFFF, reset value of TIMER_CMP

Ports:
clk  input  1  system clock, single domain
reset_n  input  1  asynchronous active-low reset
mem_addr  input  30  word address (byte address [31:2])
mem_ce  input  4  per-byte-lane chip enable, lane k = bits [8k+7:8k]
mem_we  input  4  per-byte-lane write enable
mem_d  input  32  write data, already lane-aligned
mem_q  output  32  read data, lane-aligned, valid the cycle after the request
led  output  8  LED register contents
timer_irq  output  1  level interrupt, equals STATUS[0]

Behaviour:
- Region decode: mem_addr[29]=0 selects RAM, which aliases modulo 2^ADDR_WIDTH on mem_addr[ADDR_WIDTH-1:0]. mem_addr[29]=1 selects MMIO, with register select mem_addr[1:0]; MMIO aliases across all remaining bits.
- Request classes per cycle:
  - Idle: mem_ce==0.
  - Read: mem_ce!=0 and (mem_we & mem_ce)==0.
  - Write: (mem_we & mem_ce)!=0.
  - Any mem_we bit whose mem_ce bit is 0 is ignored.
- Write: lane k is updated at the clock edge iff mem_ce[k]&mem_we[k]. Other lanes keep their contents.
- Read: at the edge, mem_q <= addressed word with lanes where mem_ce[k]=0 forced to 8'h00. Latency is exactly 1 cycle.
- mem_q holds its value on idle and write cycles. A write never changes mem_q, including a write to the address just read.
- Back-to-back reads at full rate; each returns the data as of its own request cycle.
- A read on cycle n+1 of a word written on cycle n returns the new data.
- MMIO map (word index):
  - 0 LED: rw; bits [7:0] drive led; lanes 1..3 read 0, writes to them ignored.
  - 1 CYCLE: rw 32-bit; increments by 1 every cycle, wraps FFFF_FFFF->0. A lane write loads that lane; written lanes take the written value that cycle with no increment; unwritten lanes take the incremented value.
  - 2 TIMER_CMP: rw 32-bit, byte-lane writable.
  - 3 STATUS: bit0 timer_hit, other bits read 0. Writing 1 to bit0 (lane 0 enabled) clears it; writing 0 has no effect.
- Timer: when the current CYCLE value equals TIMER_CMP, STATUS[0] is set at that edge. If a set and a W1C clear occur in the same cycle, the set wins.
- MMIO read of CYCLE returns the value before that cycle's increment.
- Reset values, applied asynchronously with no clock needed: mem_q=0, led=0, CYCLE=0, TIMER_CMP=CMP_RESET, STATUS=0, timer_irq=0.
- RAM contents are not reset and are undefined at power-up.
- Reset asserted mid-operation: the in-flight read result is discarded (mem_q=0). No RAM write occurs while reset_n=0.

Decomposition:
- Shared package/header data_memory_param.vh holds:
  - MMIO region select bit (29)
  - register indices LED=0, CYCLE=1, TIMER_CMP=2, STATUS=3
  - STATUS bit position
  - CMP_RESET default
- Sub-module data_memory_bank: one 8-bit-wide, 2^ADDR_WIDTH-deep synchronous RAM lane with ce/we, written so it infers M10K. It is instantiated 4 times.
- The top-level handles decode, lane masking, the output register mux and MMIO.

Test Plan:
- SW: ce=F, we=F, addr=0x004, d=0xDEADBEEF; then read ce=F, we=0 -> next cycle mem_q=0xDEADBEEF.
- SB: lane 2 (ce=4, we=4, d=0x00AA0000) over that word; LHU upper read (ce=C) -> mem_q=0xDEAA0000. LB lane 0 read (ce=1) -> mem_q=0x000000EF.
- Write with we=F, ce=3, d=0x11223344 to addr 0x008 pre-filled with 0 -> memory word becomes 0x00003344. Also check mem_q is unchanged during the write cycle.
- Write LED (addr 0x20000000, ce=1, we=1, d=0x5A) -> led=0x5A next cycle. A read returns 0x0000005A; a write to lane 1 leaves led unchanged.
- Write CYCLE=0x00000010, TIMER_CMP=0x00000015 -> timer_irq rises the cycle after CYCLE reaches 0x15. W1C STATUS (d=1) clears it; a write with d=0 does not.
- Assert reset_n=0 for 1 cycle while a read is outstanding -> mem_q=0, led=0, CYCLE=0, TIMER_CMP=FFFFFFFF, timer_irq=0 immediately. After release, RAM data written before reset still reads back.
